// File: rtl/snn_fp_pkg.sv
// ----------------------------------------------------------------------------
// snn_fp_pkg : float32 helpers and LIF FSM states            | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package snn_fp_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t FP_ZERO     = 32'h0000_0000;
  localparam float32_t FP_ONE      = 32'h3F80_0000;
  localparam float32_t FP_NAN_MASK = 32'h7F80_0000;
  localparam float32_t FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    LEAK  = 2'd2,
    CHECK = 2'd3
  } lif_state_e;

  function automatic logic is_nan(input float32_t x);
    return ((x & FP_NAN_MASK) == FP_NAN_MASK) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_neg(input float32_t x);
    return x[31];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_add_sub.sv
// ----------------------------------------------------------------------------
// fp32_add_sub : combinational float32 add/sub, RNE, denormals flushed | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp32_add_sub
  import snn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  output logic [31:0] result,
  output logic        exception
);

  logic               w_a_sgn, w_b_sgn;
  logic               w_a_zero, w_b_zero;
  logic               w_a_inf, w_b_inf;
  logic               w_a_nan, w_b_nan;
  logic [30:0]        w_a_key, w_b_key;
  logic [26:0]        w_a_ext, w_b_ext;
  logic               w_swap;
  logic               w_big_sgn, w_sml_sgn;
  logic [7:0]         w_big_exp, w_sml_exp, w_diff;
  logic [26:0]        w_big_ext, w_sml_ext, w_sml_sh, w_mask;
  logic               w_sticky;
  logic               w_eff_sub;
  logic [27:0]        w_sum;
  logic [4:0]         w_lz;
  logic [26:0]        w_norm;
  logic signed [9:0]  w_exp_n;
  logic               w_round_up;
  logic [24:0]        w_mant_r;
  logic [22:0]        w_frac;

  always_comb begin
    w_a_sgn  = a[31];
    w_b_sgn  = b[31] ^ op_sub;
    // Zero exponent covers denormals: they are treated as signed zero.
    w_a_zero = (a[30:23] == 8'd0);
    w_b_zero = (b[30:23] == 8'd0);
    w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    w_a_nan  = is_nan(a);
    w_b_nan  = is_nan(b);
    w_a_key  = w_a_zero ? 31'd0 : a[30:0];
    w_b_key  = w_b_zero ? 31'd0 : b[30:0];
    w_a_ext  = w_a_zero ? 27'd0 : {1'b1, a[22:0], 3'b000};
    w_b_ext  = w_b_zero ? 27'd0 : {1'b1, b[22:0], 3'b000};

    w_swap    = (w_b_key > w_a_key);
    w_big_sgn = w_swap ? w_b_sgn  : w_a_sgn;
    w_sml_sgn = w_swap ? w_a_sgn  : w_b_sgn;
    w_big_exp = w_swap ? b[30:23] : a[30:23];
    w_sml_exp = w_swap ? a[30:23] : b[30:23];
    w_big_ext = w_swap ? w_b_ext  : w_a_ext;
    w_sml_ext = w_swap ? w_a_ext  : w_b_ext;

    // Align the smaller operand; shifted-out bits collapse into the LSB sticky.
    w_diff = w_big_exp - w_sml_exp;
    w_mask = ~({27{1'b1}} << w_diff);
    if (w_diff >= 8'd27) begin
      w_sml_sh = 27'd0;
      w_sticky = |w_sml_ext;
    end else begin
      w_sml_sh = w_sml_ext >> w_diff;
      w_sticky = |(w_sml_ext & w_mask);
    end
    w_sml_sh = w_sml_sh | {26'd0, w_sticky};

    w_eff_sub = w_big_sgn ^ w_sml_sgn;
    w_sum     = w_eff_sub ? ({1'b0, w_big_ext} - {1'b0, w_sml_sh})
                          : ({1'b0, w_big_ext} + {1'b0, w_sml_sh});

    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end

    w_exp_n = $signed({2'b00, w_big_exp});
    if (w_sum[27]) begin
      w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp_n = w_exp_n + 10'sd1;
    end else begin
      w_norm  = w_sum[26:0] << w_lz;
      w_exp_n = w_exp_n - $signed({5'd0, w_lz});
    end

    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r   = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
    if (w_mant_r[24]) begin
      w_exp_n = w_exp_n + 10'sd1;
      w_frac  = w_mant_r[23:1];
    end else begin
      w_frac  = w_mant_r[22:0];
    end

    exception = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sgn != w_b_sgn))) begin
      result    = FP_QNAN;
      exception = 1'b1;
    end else if (w_a_inf) begin
      result = {w_a_sgn, 8'hFF, 23'd0};
    end else if (w_b_inf) begin
      result = {w_b_sgn, 8'hFF, 23'd0};
    end else if (w_sum == 28'd0) begin
      result = {(w_eff_sub ? 1'b0 : w_big_sgn), 31'd0};
    end else if (w_exp_n >= 10'sd255) begin
      result = {w_big_sgn, 8'hFF, 23'd0};
    end else if (w_exp_n <= 10'sd0) begin
      result = {w_big_sgn, 31'd0};
    end else begin
      result = {w_big_sgn, w_exp_n[7:0], w_frac};
    end
  end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_update.sv
// ----------------------------------------------------------------------------
// lif_neuron_update : LIF membrane integrate/leak/threshold stage | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lif_neuron_update
  import snn_fp_pkg::*;
#(
  parameter logic [11:0] NEURON_ADDRESS = 12'd0,
  parameter logic [31:0] V_THRESH       = 32'h42C8_0000,
  parameter logic [31:0] V_LEAK         = 32'h3F80_0000,
  parameter logic [31:0] V_REST         = 32'h0000_0000,
  parameter int unsigned REFRACT_STEPS  = 2
) (
  input  logic        CLK_Neuron,
  input  logic        RESET_n,
  input  logic        mac_done,
  input  logic [31:0] mac_sum,
  output logic        spike_valid,
  output logic [11:0] spike_address,
  output logic [31:0] v_mem,
  output logic        busy,
  output logic        overrun
);

  localparam int RC_W = (REFRACT_STEPS > 1) ? $clog2(REFRACT_STEPS + 1) : 1;

  lif_state_e  state_q, state_d;
  logic        buf_full_q, buf_full_d;
  float32_t    buf_data_q, buf_data_d;
  float32_t    in_reg_q, in_reg_d;
  float32_t    acc_q, acc_d;
  logic        acc_nan_q, acc_nan_d;
  float32_t    v_mem_q, v_mem_d;
  logic [RC_W-1:0] refract_q, refract_d;
  logic        spike_valid_q, spike_valid_d;
  logic [11:0] spike_address_q, spike_address_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic        w_dequeue;
  float32_t    w_add_a, w_add_b, w_add_res;
  logic        w_add_sub, w_add_exc;

  // Single adder time-shared between the ADD and LEAK states.
  fp32_add_sub u_fp32_add_sub (
    .a         (w_add_a),
    .b         (w_add_b),
    .op_sub    (w_add_sub),
    .result    (w_add_res),
    .exception (w_add_exc)
  );

  always_comb begin
    state_d         = state_q;
    buf_full_d      = buf_full_q;
    buf_data_d      = buf_data_q;
    in_reg_d        = in_reg_q;
    acc_d           = acc_q;
    acc_nan_d       = acc_nan_q;
    v_mem_d         = v_mem_q;
    refract_d       = refract_q;
    spike_valid_d   = 1'b0;
    spike_address_d = spike_address_q;
    overrun_d       = overrun_q;
    w_add_a         = v_mem_q;
    w_add_b         = in_reg_q;
    w_add_sub       = 1'b0;

    w_dequeue = (state_q == IDLE) && buf_full_q;
    if (w_dequeue) buf_full_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          in_reg_d = buf_data_q;
          if (refract_q != '0) begin
            refract_d = refract_q - RC_W'(1);
            v_mem_d   = V_REST;
          end else begin
            state_d = ADD;
          end
        end
      end
      ADD: begin
        acc_d     = w_add_res;
        acc_nan_d = w_add_exc;
        state_d   = LEAK;
      end
      LEAK: begin
        w_add_a   = acc_q;
        w_add_b   = V_LEAK;
        w_add_sub = 1'b1;
        acc_d     = w_add_res;
        acc_nan_d = w_add_exc;
        state_d   = CHECK;
      end
      CHECK: begin
        // Both operands are non-negative here, so magnitude bits compare exactly.
        if (acc_nan_q || is_nan(acc_q)) begin
          v_mem_d = V_REST;
        end else if (is_neg(acc_q)) begin
          v_mem_d = V_REST;
        end else if (acc_q[30:0] >= V_THRESH[30:0]) begin
          spike_valid_d   = 1'b1;
          spike_address_d = NEURON_ADDRESS;
          v_mem_d         = V_REST;
          refract_d       = RC_W'(REFRACT_STEPS);
        end else begin
          v_mem_d = acc_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mac_done) begin
      if (!buf_full_q || w_dequeue) begin
        buf_full_d = 1'b1;
        buf_data_d = mac_sum;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE) || buf_full_d;
  end

  always_ff @(posedge CLK_Neuron or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q         <= IDLE;
      buf_full_q      <= 1'b0;
      buf_data_q      <= FP_ZERO;
      in_reg_q        <= FP_ZERO;
      acc_q           <= FP_ZERO;
      acc_nan_q       <= 1'b0;
      v_mem_q         <= V_REST;
      refract_q       <= '0;
      spike_valid_q   <= 1'b0;
      spike_address_q <= 12'd0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_full_q      <= buf_full_d;
      buf_data_q      <= buf_data_d;
      in_reg_q        <= in_reg_d;
      acc_q           <= acc_d;
      acc_nan_q       <= acc_nan_d;
      v_mem_q         <= v_mem_d;
      refract_q       <= refract_d;
      spike_valid_q   <= spike_valid_d;
      spike_address_q <= spike_address_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
    end
  end

  assign spike_valid   = spike_valid_q;
  assign spike_address = spike_address_q;
  assign v_mem         = v_mem_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

`default_nettype wire
